// File: rtl/ov7670_pkg.sv
// Shared encodings for the OV7670 sensor emulator: pattern modes, RGB565
// bar colours and the frame FSM states.
package ov7670_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov7670_if.sv
// Camera pixel bus: control inputs (enable/mode) plus the sensor-side outputs.
interface ov7670_if;
  logic        enable;
  logic [1:0]  mode;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  // master = the emulated sensor
  modport master (
    input  enable, mode,
    output vsync, href, d, busy, frame_done, frame_count
  );

  // slave = whoever controls the emulator and consumes its pixel stream
  modport slave (
    output enable, mode,
    input  vsync, href, d, busy, frame_done, frame_count
  );
endinterface

// File: rtl/ov7670_pixel_pattern.sv
// Combinational test-pattern source: RGB565 pixel for column x in the
// latched mode. Reserved mode falls back to colour bars.
module ov7670_pixel_pattern
  import ov7670_pkg::*;
#(
  parameter int          H_ACTIVE    = 640,
  parameter int          XW          = 10,
  parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
  input  logic [XW-1:0] x,
  input  mode_e         mode,
  output logic [15:0]   pix
);

  // eight equal-width bars across the active line
  logic [2:0] bar;
  assign bar = 3'((32'(x) * 32'd8) / 32'(H_ACTIVE));

  // pattern select
  always_comb begin
    pix = C_BLACK;
    case (mode)
      MODE_RAMP:  pix = 16'(x);
      MODE_SOLID: pix = SOLID_COLOR;
      default: begin
        case (bar)
          3'd0: pix = C_WHITE;
          3'd1: pix = C_YELLOW;
          3'd2: pix = C_CYAN;
          3'd3: pix = C_GREEN;
          3'd4: pix = C_MAGENTA;
          3'd5: pix = C_RED;
          3'd6: pix = C_BLUE;
          default: pix = C_BLACK;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ov7670_pattern_gen.sv
// OV7670 sensor emulator: produces VSYNC/HREF/byte data with camera frame
// timing. Next-cycle state is computed combinationally and every output is
// registered from it, so outputs line up exactly with the state they describe.
module ov7670_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          H_BLANK     = 144,
  parameter int          VSYNC_LINES = 3,
  parameter int          V_BACK      = 17,
  parameter int          V_FRONT     = 10,
  parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
  input  logic     clk_24,
  input  logic     reset_n,
  ov7670_if.master cam
);

  localparam int L      = 2*H_ACTIVE + H_BLANK;
  localparam int COL_W  = (L > 1) ? $clog2(L) : 1;
  localparam int MAXL   = max2(max2(VSYNC_LINES, V_BACK), max2(V_ACTIVE, V_FRONT));
  localparam int LINE_W = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam int XW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(L - 1);
  localparam logic [COL_W-1:0]  HREF_END  = COL_W'(2*H_ACTIVE);
  localparam logic [LINE_W-1:0] VF_LAST   = LINE_W'(V_FRONT - 1);

  state_e            state_q, nxt_state;
  logic [COL_W-1:0]  col_q, nxt_col;
  logic [LINE_W-1:0] line_q, nxt_line, line_last;
  mode_e             mode_q, nxt_mode;
  logic [15:0]       frame_cnt;

  logic              href_n, done_n;
  logic [7:0]        d_n;
  logic [15:0]       pix;
  logic [XW-1:0]     x_n;

  // number of line periods in the current phase, minus one
  always_comb begin
    case (state_q)
      ST_VSYNC:  line_last = LINE_W'(VSYNC_LINES - 1);
      ST_VBACK:  line_last = LINE_W'(V_BACK - 1);
      ST_ACTIVE: line_last = LINE_W'(V_ACTIVE - 1);
      default:   line_last = VF_LAST;
    endcase
  end

  // frame sequencing: byte column within a line period, line within a phase
  always_comb begin
    nxt_state = state_q;
    nxt_col   = col_q;
    nxt_line  = line_q;
    nxt_mode  = mode_q;
    if (state_q == ST_IDLE) begin
      nxt_col  = '0;
      nxt_line = '0;
      if (cam.enable) begin
        nxt_state = ST_VSYNC;
        nxt_mode  = mode_e'(cam.mode);
      end
    end else if (col_q != COL_LAST) begin
      nxt_col = col_q + 1'b1;
    end else begin
      nxt_col = '0;
      if (line_q != line_last) begin
        nxt_line = line_q + 1'b1;
      end else begin
        nxt_line = '0;
        case (state_q)
          ST_VSYNC:  nxt_state = ST_VBACK;
          ST_VBACK:  nxt_state = ST_ACTIVE;
          ST_ACTIVE: nxt_state = ST_VFRONT;
          default: begin
            // end of frame: chain straight into the next VSYNC if still enabled
            if (cam.enable) begin
              nxt_state = ST_VSYNC;
              nxt_mode  = mode_e'(cam.mode);
            end else begin
              nxt_state = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign x_n = XW'(nxt_col >> 1);

  ov7670_pixel_pattern #(
    .H_ACTIVE    (H_ACTIVE),
    .XW          (XW),
    .SOLID_COLOR (SOLID_COLOR)
  ) u_pattern (
    .x    (x_n),
    .mode (nxt_mode),
    .pix  (pix)
  );

  // byte phase 0 carries the high byte; data is forced low outside HREF
  always_comb begin
    href_n = (nxt_state == ST_ACTIVE) && (nxt_col < HREF_END);
    d_n    = 8'h00;
    if (href_n) d_n = nxt_col[0] ? pix[7:0] : pix[15:8];
    done_n = (nxt_state == ST_VFRONT) && (nxt_col == COL_LAST) && (nxt_line == VF_LAST);
  end

  // state and registered outputs
  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      col_q          <= '0;
      line_q         <= '0;
      mode_q         <= MODE_BARS;
      frame_cnt      <= '0;
      cam.vsync      <= 1'b0;
      cam.href       <= 1'b0;
      cam.d          <= 8'h00;
      cam.busy       <= 1'b0;
      cam.frame_done <= 1'b0;
    end else begin
      state_q        <= nxt_state;
      col_q          <= nxt_col;
      line_q         <= nxt_line;
      mode_q         <= nxt_mode;
      cam.vsync      <= (nxt_state == ST_VSYNC);
      cam.href       <= href_n;
      cam.d          <= d_n;
      cam.busy       <= (nxt_state != ST_IDLE);
      cam.frame_done <= done_n;
      if (done_n) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign cam.frame_count = frame_cnt;

endmodule

// File: tb/tb_ov7670_pattern_gen.sv
// Self-checking bench for ov7670_pattern_gen with a small frame geometry.
module tb_ov7670_pattern_gen;

  localparam int HA = 8, VA = 4, HB = 4, VS = 2, VB = 1, VF = 1;
  localparam int L = 2*HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * L;
  localparam logic [15:0] BAR_TAB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic clk_24 = 1'b0;
  logic reset_n;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   exp_cnt = 0;

  logic [11:0] obs [FRAME];
  logic [15:0] cnt_at_done;

  ov7670_if cam ();

  ov7670_pattern_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF), .SOLID_COLOR(16'hF800)
  ) dut (
    .clk_24  (clk_24),
    .reset_n (reset_n),
    .cam     (cam)
  );

  always #5 clk_24 = ~clk_24;

  // reference: {vsync, href, busy, frame_done, d} at cycle t of a frame
  function automatic logic [11:0] model(input int t, input int m);
    int line, col, x;
    logic vs, hr, fd;
    logic [15:0] pix;
    logic [7:0] dd;
    line = t / L;
    col  = t % L;
    x    = col / 2;
    vs   = line < VS;
    hr   = (line >= VS + VB) && (line < VS + VB + VA) && (col < 2*HA);
    case (m)
      1:       pix = 16'(x);
      2:       pix = 16'hF800;
      default: pix = BAR_TAB[(x*8)/HA];
    endcase
    dd = !hr ? 8'h00 : ((col % 2 == 0) ? pix[15:8] : pix[7:0]);
    fd = (t == FRAME - 1);
    return {vs, hr, 1'b1, fd, dd};
  endfunction

  // record one frame of outputs; optionally drop enable / change mode on the way
  task automatic capture(input int en_cycles, input int chg_at, input logic [1:0] chg_mode);
    cnt_at_done = 'x;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk_24);
      obs[i] = {cam.vsync, cam.href, cam.busy, cam.frame_done, cam.d};
      if (cam.frame_done) cnt_at_done = cam.frame_count;
      if (i + 1 == en_cycles) cam.enable = 1'b0;
      if (i == chg_at) cam.mode = chg_mode;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cam.enable = 1'b0;
    cam.mode = 2'd0;
    repeat (3) @(negedge clk_24);
    chk_cnt++;
    if ({cam.vsync, cam.href, cam.d, cam.busy, cam.frame_done, cam.frame_count} !== 28'h0)
      $display("FAIL reset_state got vs=%b hr=%b d=%h busy=%b fd=%b cnt=%h want all 0",
               cam.vsync, cam.href, cam.d, cam.busy, cam.frame_done, cam.frame_count);
    else pass_cnt++;
    reset_n = 1'b1;
    exp_cnt = 0;
    repeat (3) @(negedge clk_24);
    chk_cnt++;
    if ({cam.vsync, cam.busy} !== 2'b00)
      $display("FAIL idle_after_reset got vs=%b busy=%b want 0 0", cam.vsync, cam.busy);
    else pass_cnt++;
  endtask

  task automatic test_bars_single;
    int m;
    m = ($urandom_range(0, 1) == 0) ? 0 : 3;
    cam.mode = 2'(m);
    cam.enable = 1'b1;
    capture(1, -1, 2'd0);
    for (int i = 0; i < FRAME; i++) begin
      chk_cnt++;
      if (obs[i] !== model(i, m))
        $display("FAIL bars_frame t=%0d got %h want %h", i, obs[i], model(i, m));
      else pass_cnt++;
    end
    exp_cnt++;
    chk_cnt++;
    if (cnt_at_done !== 16'(exp_cnt))
      $display("FAIL bars_count got %h want %h", cnt_at_done, 16'(exp_cnt));
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_24);
      chk_cnt++;
      if ({cam.vsync, cam.href, cam.busy, cam.frame_done} !== 4'b0)
        $display("FAIL bars_idle t=%0d got vs=%b hr=%b busy=%b fd=%b want 0",
                 i, cam.vsync, cam.href, cam.busy, cam.frame_done);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    int nfr;
    nfr = $urandom_range(2, 4);
    cam.mode = 2'd1;
    cam.enable = 1'b1;
    for (int k = 0; k < nfr; k++) begin
      capture((k == nfr - 1) ? 1 : -1, -1, 2'd0);
      for (int i = 0; i < FRAME; i++) begin
        chk_cnt++;
        if (obs[i] !== model(i, 1))
          $display("FAIL ramp_frame%0d t=%0d got %h want %h", k, i, obs[i], model(i, 1));
        else pass_cnt++;
      end
      exp_cnt++;
      chk_cnt++;
      if (cnt_at_done !== 16'(exp_cnt))
        $display("FAIL ramp_count%0d got %h want %h", k, cnt_at_done, 16'(exp_cnt));
      else pass_cnt++;
    end
    @(negedge clk_24);
  endtask

  task automatic test_mode_change;
    int chg;
    chg = $urandom_range(60, 139);
    cam.mode = 2'd2;
    cam.enable = 1'b1;
    capture(-1, chg, 2'd0);
    for (int i = 0; i < FRAME; i++) begin
      chk_cnt++;
      if (obs[i] !== model(i, 2))
        $display("FAIL solid_frame t=%0d got %h want %h", i, obs[i], model(i, 2));
      else pass_cnt++;
    end
    exp_cnt++;
    capture(1, -1, 2'd0);
    for (int i = 0; i < FRAME; i++) begin
      chk_cnt++;
      if (obs[i] !== model(i, 0))
        $display("FAIL relatch_frame t=%0d got %h want %h", i, obs[i], model(i, 0));
      else pass_cnt++;
    end
    exp_cnt++;
    chk_cnt++;
    if (cnt_at_done !== 16'(exp_cnt))
      $display("FAIL relatch_count got %h want %h", cnt_at_done, 16'(exp_cnt));
    else pass_cnt++;
    @(negedge clk_24);
  endtask

  task automatic test_enable_drop;
    int m, drop;
    m = $urandom_range(0, 3);
    drop = $urandom_range(41, 60);
    cam.mode = 2'(m);
    cam.enable = 1'b1;
    capture(drop, -1, 2'd0);
    for (int i = 0; i < FRAME; i++) begin
      chk_cnt++;
      if (obs[i] !== model(i, m))
        $display("FAIL drop_frame t=%0d got %h want %h", i, obs[i], model(i, m));
      else pass_cnt++;
    end
    exp_cnt++;
    chk_cnt++;
    if (cnt_at_done !== 16'(exp_cnt))
      $display("FAIL drop_count got %h want %h", cnt_at_done, 16'(exp_cnt));
    else pass_cnt++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_24);
      chk_cnt++;
      if ({cam.vsync, cam.busy} !== 2'b00)
        $display("FAIL drop_idle t=%0d got vs=%b busy=%b want 0 0", i, cam.vsync, cam.busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset;
    int m, tgt;
    m = $urandom_range(0, 3);
    tgt = 60 + $urandom_range(0, 3) * 20 + $urandom_range(0, 15);
    cam.mode = 2'(m);
    cam.enable = 1'b1;
    for (int i = 0; i <= tgt; i++) @(negedge clk_24);
    chk_cnt++;
    if (cam.href !== 1'b1) $display("FAIL arst_pre_href got %b want 1", cam.href);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({cam.vsync, cam.href, cam.d, cam.busy, cam.frame_done, cam.frame_count} !== 28'h0)
      $display("FAIL arst_immediate got vs=%b hr=%b d=%h busy=%b fd=%b cnt=%h want all 0",
               cam.vsync, cam.href, cam.d, cam.busy, cam.frame_done, cam.frame_count);
    else pass_cnt++;
    exp_cnt = 0;
    repeat (2) @(negedge clk_24);
    reset_n = 1'b1;
    chk_cnt++;
    if (cam.frame_count !== 16'h0)
      $display("FAIL arst_count_cleared got %h want 0000", cam.frame_count);
    else pass_cnt++;
    capture(1, -1, 2'd0);
    for (int i = 0; i < FRAME; i++) begin
      chk_cnt++;
      if (obs[i] !== model(i, m))
        $display("FAIL arst_frame t=%0d got %h want %h", i, obs[i], model(i, m));
      else pass_cnt++;
    end
    exp_cnt++;
    chk_cnt++;
    if (cnt_at_done !== 16'(exp_cnt))
      $display("FAIL arst_count got %h want %h", cnt_at_done, 16'(exp_cnt));
    else pass_cnt++;
    @(negedge clk_24);
  endtask

  task automatic test_wrap;
    int m;
    m = $urandom_range(0, 3);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk_24);
    release dut.frame_cnt;
    @(negedge clk_24);
    chk_cnt++;
    if (cam.frame_count !== 16'hFFFF)
      $display("FAIL wrap_preload got %h want ffff", cam.frame_count);
    else pass_cnt++;
    cam.mode = 2'(m);
    cam.enable = 1'b1;
    capture(1, -1, 2'd0);
    for (int i = 0; i < FRAME; i++) begin
      chk_cnt++;
      if (obs[i] !== model(i, m))
        $display("FAIL wrap_frame t=%0d got %h want %h", i, obs[i], model(i, m));
      else pass_cnt++;
    end
    chk_cnt++;
    if (cnt_at_done !== 16'h0000)
      $display("FAIL wrap_count got %h want 0000", cnt_at_done);
    else pass_cnt++;
    repeat (5) @(negedge clk_24);
    chk_cnt++;
    if ({cam.busy, cam.frame_count} !== 17'h0)
      $display("FAIL wrap_idle got busy=%b cnt=%h want 0 0000", cam.busy, cam.frame_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bars_single();
    test_back_to_back();
    test_mode_change();
    test_enable_drop();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
